pim_tile_scheduler: RTL and testbench

Parametrised successor controller for PIM matrix multiply: latches A/B on start and splits C = A×B into CHUNK_SIZE×CHUNK_SIZE output tiles and PIM_UNIT_CAPACITY-deep k-slices. Dispatches slices to NUM_UNITS external pim_unit lanes over a valid/ready handshake and accumulates partial tiles. Supports fewer lanes than tiles: lane u serves tiles u, u+NUM_UNITS, … in order. Sits between top-level memory FSM and the pim_unit array.

---
 rtl/pim_tile_scheduler_if.sv | 25 ++
 rtl/pim_tile_scheduler.sv | 170 +++++++++++++++++
 tb/tb_pim_tile_scheduler.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pim_tile_scheduler_if.sv
// Lane-side bus between pim_tile_scheduler and the pim_unit array.
// master = scheduler (issues slices), slave = pim_unit lanes (accept and return partial tiles).
interface pim_tile_scheduler_if #(
   parameter int WIDTH             = 16,
   parameter int CHUNK_SIZE        = 2,
   parameter int PIM_UNIT_CAPACITY = 4,
   parameter int NUM_UNITS         = 4
);
   logic [NUM_UNITS-1:0]                                 unit_valid;
   logic [NUM_UNITS-1:0]                                 unit_ready;
   logic [NUM_UNITS*CHUNK_SIZE*PIM_UNIT_CAPACITY*WIDTH-1:0] unit_a;
   logic [NUM_UNITS*PIM_UNIT_CAPACITY*CHUNK_SIZE*WIDTH-1:0] unit_b;
   logic [NUM_UNITS*CHUNK_SIZE*CHUNK_SIZE*WIDTH-1:0]        unit_result;
   logic [NUM_UNITS-1:0]                                 unit_result_valid;

   modport master (
      output unit_valid, unit_a, unit_b,
      input  unit_ready, unit_result, unit_result_valid
   );

   modport slave (
      input  unit_valid, unit_a, unit_b,
      output unit_ready, unit_result, unit_result_valid
   );
endinterface

// File: rtl/pim_tile_scheduler.sv
// Tiles C = A x B into CHUNK_SIZE^2 output tiles and PIM_UNIT_CAPACITY-deep k-slices, dispatched over NUM_UNITS lanes.
// Define PIM_ZERO_SKIP_EN to skip slices whose every product term is zero. Matrices are row-major, element 0 in the LSBs.
module pim_tile_scheduler #(
   parameter int WIDTH             = 16,
   parameter int MATRIX_SIZE       = 8,
   parameter int CHUNK_SIZE        = 2,
   parameter int PIM_UNIT_CAPACITY = 4,
   parameter int NUM_UNITS         = 4
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  start,
   input  logic [WIDTH*MATRIX_SIZE*MATRIX_SIZE-1:0] matrix_A,
   input  logic [WIDTH*MATRIX_SIZE*MATRIX_SIZE-1:0] matrix_B,
   pim_tile_scheduler_if.master                  lanes,
   output logic                                  busy,
   output logic [WIDTH*MATRIX_SIZE*MATRIX_SIZE-1:0] result,
   output logic                                  result_ready
);
   localparam int M   = MATRIX_SIZE;
   localparam int C   = CHUNK_SIZE;
   localparam int P   = PIM_UNIT_CAPACITY;
   localparam int TPR = M / C;
   localparam int T   = TPR * TPR;
   localparam int S   = M / P;
   localparam int MW  = WIDTH * M * M;
   localparam int TW  = $clog2(T + NUM_UNITS + 1);
   localparam int SW  = $clog2(S + 1);

   typedef enum logic [1:0] {IDLE, RUN, FIN} top_t;
   typedef enum logic [2:0] {L_IDLE, L_CHECK, L_ISSUE, L_WAIT, L_NEXT, L_DONE} lane_t;

   top_t                 top_state, top_next;
   lane_t                lane_state [NUM_UNITS];
   lane_t                lane_next  [NUM_UNITS];
   logic [TW-1:0]        tile  [NUM_UNITS];
   logic [SW-1:0]        slice [NUM_UNITS];
   logic [WIDTH-1:0]     acc   [NUM_UNITS][C*C];
   logic [MW-1:0]        a_reg, b_reg;
   logic [NUM_UNITS-1:0] zero_slice;
   logic [NUM_UNITS-1:0] all_done;
   int                   tile_row [NUM_UNITS];
   int                   tile_col [NUM_UNITS];
   logic                 job_start;

   assign job_start    = (top_state == IDLE) && start;
   assign busy         = (top_state == RUN);
   assign result_ready = (top_state == FIN);

   // Slice extraction: each lane presents the A rows / B columns of its current tile and k-slice.
   always_comb begin
      lanes.unit_a     = '0;
      lanes.unit_b     = '0;
      lanes.unit_valid = '0;
      zero_slice       = '0;
      for (int u = 0; u < NUM_UNITS; u++) begin
         tile_row[u] = 0;
         tile_col[u] = 0;
         if (int'(tile[u]) < T) begin
            tile_row[u] = int'(tile[u]) / TPR;
            tile_col[u] = int'(tile[u]) % TPR;
         end
         lanes.unit_valid[u] = (lane_state[u] == L_ISSUE);
         for (int i = 0; i < C; i++)
            for (int k = 0; k < P; k++)
               lanes.unit_a[((u*C+i)*P+k)*WIDTH +: WIDTH] =
                  a_reg[((tile_row[u]*C+i)*M + int'(slice[u])*P + k)*WIDTH +: WIDTH];
         for (int k = 0; k < P; k++)
            for (int j = 0; j < C; j++)
               lanes.unit_b[((u*P+k)*C+j)*WIDTH +: WIDTH] =
                  b_reg[((int'(slice[u])*P+k)*M + tile_col[u]*C + j)*WIDTH +: WIDTH];
`ifdef PIM_ZERO_SKIP_EN
         zero_slice[u] = 1'b1;
         for (int i = 0; i < C; i++)
            for (int k = 0; k < P; k++)
               for (int j = 0; j < C; j++)
                  if (lanes.unit_a[((u*C+i)*P+k)*WIDTH +: WIDTH] != '0 &&
                      lanes.unit_b[((u*P+k)*C+j)*WIDTH +: WIDTH] != '0)
                     zero_slice[u] = 1'b0;
`else
         zero_slice[u] = 1'b0;
`endif
      end
   end

   always_comb begin
      top_next = top_state;
      for (int u = 0; u < NUM_UNITS; u++) all_done[u] = (lane_state[u] == L_DONE);
      case (top_state)
         IDLE:    if (start) top_next = RUN;
         RUN:     if (&all_done) top_next = FIN;
         FIN:     top_next = IDLE;
         default: top_next = IDLE;
      endcase
      for (int u = 0; u < NUM_UNITS; u++) begin
         lane_next[u] = lane_state[u];
         case (lane_state[u])
            L_IDLE:  if (job_start) lane_next[u] = (u < T) ? L_CHECK : L_DONE;
            L_CHECK: lane_next[u] = zero_slice[u] ? L_NEXT : L_ISSUE;
            L_ISSUE: if (lanes.unit_ready[u]) lane_next[u] = L_WAIT;
            L_WAIT:  if (lanes.unit_result_valid[u]) lane_next[u] = L_NEXT;
            L_NEXT: begin
               if (slice[u] < SW'(S - 1))                lane_next[u] = L_CHECK;
               else if (int'(tile[u]) + NUM_UNITS >= T) lane_next[u] = L_DONE;
               else                                     lane_next[u] = L_CHECK;
            end
            L_DONE:  if (top_state == FIN) lane_next[u] = L_IDLE;
            default: lane_next[u] = L_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         top_state <= IDLE;
         for (int u = 0; u < NUM_UNITS; u++) lane_state[u] <= L_IDLE;
      end else begin
         top_state <= top_next;
         for (int u = 0; u < NUM_UNITS; u++) lane_state[u] <= lane_next[u];
      end
   end

   // Operands are captured once per job and need no reset.
   always_ff @(posedge clk) begin
      if (job_start) begin
         a_reg <= matrix_A;
         b_reg <= matrix_B;
      end
   end

   // Accumulate partial tiles; flush a finished tile into result on its last slice.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         result <= '0;
         for (int u = 0; u < NUM_UNITS; u++) begin
            tile[u]  <= '0;
            slice[u] <= '0;
            for (int k = 0; k < C*C; k++) acc[u][k] <= '0;
         end
      end else begin
         if (job_start) result <= '0;
         for (int u = 0; u < NUM_UNITS; u++) begin
            case (lane_state[u])
               L_IDLE: if (job_start) begin
                  tile[u]  <= TW'(u);
                  slice[u] <= '0;
                  for (int k = 0; k < C*C; k++) acc[u][k] <= '0;
               end
               L_WAIT: if (lanes.unit_result_valid[u]) begin
                  for (int k = 0; k < C*C; k++)
                     acc[u][k] <= acc[u][k] + lanes.unit_result[(u*C*C+k)*WIDTH +: WIDTH];
               end
               L_NEXT: begin
                  if (slice[u] < SW'(S - 1)) begin
                     slice[u] <= slice[u] + 1'b1;
                  end else begin
                     for (int i = 0; i < C; i++)
                        for (int j = 0; j < C; j++)
                           result[((tile_row[u]*C+i)*M + tile_col[u]*C + j)*WIDTH +: WIDTH] <= acc[u][i*C+j];
                     for (int k = 0; k < C*C; k++) acc[u][k] <= '0;
                     slice[u] <= '0;
                     tile[u]  <= tile[u] + TW'(NUM_UNITS);
                  end
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_pim_tile_scheduler.sv
// Bench for pim_tile_scheduler: table vectors, randomized jobs against a matmul reference, and
// hand-written sequences for lane stalls, start-while-busy and mid-job reset.
module tb_pim_tile_scheduler;
   localparam int W = 8, M = 4, C = 2, P = 2, N = 2;
   localparam int TPR = M / C, T = TPR * TPR, S = M / P, MW = W * M * M;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [MW-1:0] matrix_A, matrix_B, result;
   logic          busy, result_ready;

   always #5 clk = ~clk;

   pim_tile_scheduler_if #(.WIDTH(W), .CHUNK_SIZE(C), .PIM_UNIT_CAPACITY(P), .NUM_UNITS(N)) bus ();

   pim_tile_scheduler #(.WIDTH(W), .MATRIX_SIZE(M), .CHUNK_SIZE(C), .PIM_UNIT_CAPACITY(P), .NUM_UNITS(N)) dut (
      .clk(clk), .rst(rst), .start(start), .matrix_A(matrix_A), .matrix_B(matrix_B),
      .lanes(bus.master), .busy(busy), .result(result), .result_ready(result_ready)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [W-1:0] el(input logic [MW-1:0] m, input int r, input int c);
      return m[(r*M+c)*W +: W];
   endfunction

   function automatic logic [MW-1:0] matmul(input logic [MW-1:0] a, input logic [MW-1:0] b);
      logic [MW-1:0] res = '0;
      for (int r = 0; r < M; r++)
         for (int c = 0; c < M; c++) begin
            logic [W-1:0] s = '0;
            for (int k = 0; k < M; k++) s = s + el(a, r, k) * el(b, k, c);
            res[(r*M+c)*W +: W] = s;
         end
      return res;
   endfunction

   function automatic int expected_hs(input logic [MW-1:0] a, input logic [MW-1:0] b);
`ifdef PIM_ZERO_SKIP_EN
      int n = 0;
      for (int t = 0; t < T; t++)
         for (int s = 0; s < S; s++) begin
            bit nz = 0;
            for (int i = 0; i < C; i++)
               for (int k = 0; k < P; k++)
                  for (int j = 0; j < C; j++)
                     if (el(a, (t/TPR)*C+i, s*P+k) != 0 && el(b, s*P+k, (t%TPR)*C+j) != 0) nz = 1;
            if (nz) n++;
         end
      return n;
`else
      return T * S;
`endif
   endfunction

   // kind 0: fill with v; 1: identity; 2: ramp 1..M*M; 3: columns >= 2 zero, others 1
   function automatic logic [MW-1:0] mk(input int kind, input int v);
      logic [MW-1:0] m = '0;
      for (int r = 0; r < M; r++)
         for (int c = 0; c < M; c++) begin
            int e;
            case (kind)
               0: e = v;
               1: e = (r == c) ? 1 : 0;
               2: e = r*M + c + 1;
               default: e = (c >= 2) ? 0 : 1;
            endcase
            m[(r*M+c)*W +: W] = W'(e);
         end
      return m;
   endfunction

   // ---------------- pim_unit lane model: ready driven by the stimulus, result 2 cycles after accept ----------------
   int hs_count = 0;
   int valid_cycles = 0;
   int pend [N] = '{default: 0};
   logic [C*C*W-1:0] prod [N];

   function automatic logic [C*C*W-1:0] unit_mul(input int u, input logic [N*C*P*W-1:0] ua,
                                                 input logic [N*P*C*W-1:0] ub);
      logic [C*C*W-1:0] r = '0;
      for (int i = 0; i < C; i++)
         for (int j = 0; j < C; j++) begin
            logic [W-1:0] s = '0;
            for (int k = 0; k < P; k++)
               s = s + ua[((u*C+i)*P+k)*W +: W] * ub[((u*P+k)*C+j)*W +: W];
            r[(i*C+j)*W +: W] = s;
         end
      return r;
   endfunction

   always @(negedge clk) begin
      for (int u = 0; u < N; u++) begin
         bus.unit_result_valid[u] = 1'b0;
         if (pend[u] > 0) begin
            pend[u]--;
            if (pend[u] == 0) begin
               bus.unit_result_valid[u] = 1'b1;
               bus.unit_result[u*C*C*W +: C*C*W] = prod[u];
            end
         end
         if (bus.unit_valid[u]) valid_cycles++;
         if (bus.unit_valid[u] && bus.unit_ready[u]) begin
            hs_count++;
            prod[u] = unit_mul(u, bus.unit_a, bus.unit_b);
            pend[u] = 2;
         end
      end
   end

   // ---------------- job helpers ----------------
   task automatic start_job(input logic [MW-1:0] a, input logic [MW-1:0] b);
      @(negedge clk);
      matrix_A = a;
      matrix_B = b;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, input logic [MW-1:0] exp, output int cycles);
      cycles = 1;
      while (result_ready !== 1'b1 && cycles < 500) begin
         @(negedge clk);
         cycles++;
      end
      if (result_ready !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL %s timeout actual=no_result_ready required=result_ready", name);
         return;
      end
      check({name, " busy_at_pulse"}, MW'(busy), MW'(0));
      check({name, " result"}, result, exp);
      @(negedge clk);
      check({name, " pulse_width"}, MW'(result_ready), MW'(0));
      check({name, " result_hold"}, result, exp);
   endtask

   typedef struct {
      string         name;
      logic [MW-1:0] a;
      logic [MW-1:0] b;
      logic [MW-1:0] c;
   } vec_t;

   vec_t vecs [5];

   initial begin
      int cyc, hs0, vc0;
      logic [MW-1:0] a, b, snap_a, snap_b;
      bit stable;

      vecs[0] = '{"ident_ramp", mk(1, 0), mk(2, 0), mk(2, 0)};
      vecs[1] = '{"zero_a",     mk(0, 0), mk(0, 5), mk(0, 0)};
      vecs[2] = '{"last_zero",  mk(3, 0), mk(0, 1), mk(0, 2)};
      vecs[3] = '{"all8_wrap",  mk(0, 8), mk(0, 8), mk(0, 0)};
      vecs[4] = '{"all3",       mk(0, 3), mk(0, 3), mk(0, 36)};

      rst = 1'b0;
      start = 1'b0;
      matrix_A = '0;
      matrix_B = '0;
      bus.unit_ready = '1;
      repeat (2) @(negedge clk);
      check("reset busy", MW'(busy), MW'(0));
      check("reset result_ready", MW'(result_ready), MW'(0));
      check("reset unit_valid", MW'(bus.unit_valid), MW'(0));
      check("reset result", result, '0);
      rst = 1'b1;
      @(negedge clk);

      for (int v = 0; v < 5; v++) begin
         hs0 = hs_count;
         vc0 = valid_cycles;
         start_job(vecs[v].a, vecs[v].b);
         check({vecs[v].name, " busy"}, MW'(busy), MW'(1));
         wait_done(vecs[v].name, vecs[v].c, cyc);
         check({vecs[v].name, " handshakes"}, MW'(hs_count - hs0), MW'(expected_hs(vecs[v].a, vecs[v].b)));
         check({vecs[v].name, " valid_cycles"}, MW'(valid_cycles - vc0), MW'(hs_count - hs0));
`ifdef PIM_ZERO_SKIP_EN
         if (v == 1) check("zero_a latency_le_20", MW'(cyc <= 20), MW'(1));
`endif
      end

      // Lane 0 held off for 10 cycles: request and slice must stay put.
      bus.unit_ready = 2'b10;
      start_job(mk(1, 0), mk(2, 0));
      cyc = 0;
      while (bus.unit_valid[0] !== 1'b1 && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      check("stall valid_seen", MW'(bus.unit_valid[0]), MW'(1));
      snap_a = MW'(bus.unit_a[C*P*W-1:0]);
      snap_b = MW'(bus.unit_b[P*C*W-1:0]);
      stable = 1;
      repeat (10) begin
         @(negedge clk);
         if (bus.unit_valid[0] !== 1'b1 || MW'(bus.unit_a[C*P*W-1:0]) !== snap_a ||
             MW'(bus.unit_b[P*C*W-1:0]) !== snap_b) stable = 0;
      end
      check("stall stable", MW'(stable), MW'(1));
      bus.unit_ready = 2'b11;
      wait_done("stall", mk(2, 0), cyc);

      // start while busy is ignored; operand changes after latch have no effect
      hs0 = hs_count;
      a = mk(0, 3);
      b = mk(2, 0);
      start_job(a, b);
      repeat (3) @(negedge clk);
      matrix_A = mk(1, 0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done("restart_ignored", matmul(a, b), cyc);
      check("restart handshakes", MW'(hs_count - hs0), MW'(expected_hs(a, b)));
      repeat (5) @(negedge clk);
      check("restart idle_after", MW'(busy), MW'(0));

      // asynchronous reset mid-job, then a clean job
      start_job(mk(0, 3), mk(0, 3));
      repeat (14) @(negedge clk);
      #1 rst = 1'b0;
      #1;
      check("midrst busy", MW'(busy), MW'(0));
      check("midrst unit_valid", MW'(bus.unit_valid), MW'(0));
      check("midrst result_ready", MW'(result_ready), MW'(0));
      check("midrst result", result, '0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      start_job(mk(1, 0), mk(2, 0));
      wait_done("after_reset", mk(2, 0), cyc);

      // randomized sparse jobs against the reference model
      for (int n = 0; n < 8; n++) begin
         a = '0;
         b = '0;
         for (int e = 0; e < M*M; e++) begin
            if ($urandom_range(2, 0) != 0) a[e*W +: W] = W'($urandom);
            if ($urandom_range(2, 0) != 0) b[e*W +: W] = W'($urandom);
         end
         if (n % 2 == 1)
            for (int r = 0; r < M; r++)
               for (int k = P; k < 2*P; k++) a[(r*M+k)*W +: W] = '0;
         hs0 = hs_count;
         vc0 = valid_cycles;
         start_job(a, b);
         wait_done($sformatf("rand%0d", n), matmul(a, b), cyc);
         check($sformatf("rand%0d handshakes", n), MW'(hs_count - hs0), MW'(expected_hs(a, b)));
         check($sformatf("rand%0d valid_cycles", n), MW'(valid_cycles - vc0), MW'(hs_count - hs0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
